// File: rtl/final_add_scheduler.sv
// Round-robin front end for two requesters sharing one pipelined final adder.
// Define FINAL_ADD_SCHED_STATS_EN to add the stat_ops response counter.
module final_add_scheduler #(
    parameter int WIDTH         = 16,
    parameter int PIPELINE_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    input  logic [PIPELINE_BITS-1:0] cfg_pipes,
    output logic                     cfg_ready,
    output logic                     cfg_err,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [WIDTH-1:0]         req0_a,
    input  logic [WIDTH-1:0]         req0_b,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [WIDTH-1:0]         req1_a,
    input  logic [WIDTH-1:0]         req1_b,
    output logic [WIDTH-1:0]         add_in1,
    output logic [WIDTH-1:0]         add_in2,
    output logic [PIPELINE_BITS-1:0] add_pipes,
    input  logic [WIDTH-1:0]         add_out,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     busy
`ifdef FINAL_ADD_SCHED_STATS_EN
    ,
    output logic [15:0]              stat_ops
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SWITCH
    } state_t;

    state_t                   state;
    logic [PIPELINE_BITS-1:0] pend_pipes;
    logic                     rr_last;
    logic [6:0]               trk_valid;
    logic [6:0]               trk_id;
    logic [6:0]               trk_valid_nxt;
    logic [6:0]               trk_id_nxt;
    logic                     run;
    logic                     issue;
    logic                     grant_id;
    logic                     cfg_legal;
    logic [2:0]               lat;

    function automatic logic [2:0] pipes_to_lat(input logic [PIPELINE_BITS-1:0] p);
        int unsigned pv;
        pv = 32'(p);
        case (pv)
            1:       return 3'd1;
            2:       return 3'd2;
            3:       return 3'd3;
            4:       return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    assign lat       = pipes_to_lat(add_pipes);
    assign cfg_legal = (32'(cfg_pipes) <= 32'd4);
    assign run       = (state == ST_RUN) && !rst;
    assign cfg_ready = run;
    assign cfg_err   = run && cfg_valid && !cfg_legal;
    assign busy      = (|trk_valid) || (state != ST_RUN);
    assign rsp_sum   = add_out;

    // Single grant per cycle; on contention the requester not served last wins.
    always_comb begin
        issue    = 1'b0;
        grant_id = 1'b0;
        if (run) begin
            if (req0_valid && req1_valid) begin
                issue    = 1'b1;
                grant_id = ~rr_last;
            end else if (req0_valid) begin
                issue    = 1'b1;
                grant_id = 1'b0;
            end else if (req1_valid) begin
                issue    = 1'b1;
                grant_id = 1'b1;
            end
        end
        req0_ready = issue && !grant_id;
        req1_ready = issue && grant_id;
        add_in1    = '0;
        add_in2    = '0;
        if (issue) begin
            add_in1 = grant_id ? req1_a : req0_a;
            add_in2 = grant_id ? req1_b : req0_b;
        end
    end

    // An entry is dropped once it passes the tap, so an empty tracker means nothing left to return.
    always_comb begin
        trk_valid_nxt    = '0;
        trk_id_nxt       = '0;
        trk_valid_nxt[0] = issue && (lat != 3'd0);
        trk_id_nxt[0]    = grant_id;
        for (int i = 1; i < 7; i++) begin
            trk_valid_nxt[i] = trk_valid[i-1] && (3'(i) < lat);
            trk_id_nxt[i]    = trk_id[i-1];
        end
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_id    = 1'b0;
        if (lat == 3'd0) begin
            rsp_valid = issue;
            rsp_id    = issue && grant_id;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (3'(i + 1) == lat) begin
                    rsp_valid = trk_valid[i];
                    rsp_id    = trk_valid[i] && trk_id[i];
                end
            end
        end
    end

    // Pipe changes only take effect once every in-flight operation has returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            add_pipes  <= '0;
            pend_pipes <= '0;
            rr_last    <= 1'b1;
            trk_valid  <= '0;
            trk_id     <= '0;
        end else begin
            trk_valid <= trk_valid_nxt;
            trk_id    <= trk_id_nxt;
            if (issue) begin
                rr_last <= grant_id;
            end
            case (state)
                ST_RUN: begin
                    if (cfg_valid && cfg_legal) begin
                        pend_pipes <= cfg_pipes;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (trk_valid == 7'd0) begin
                        add_pipes <= pend_pipes;
                        state     <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FINAL_ADD_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops <= '0;
        end else if (rsp_valid && (stat_ops != 16'hFFFF)) begin
            stat_ops <= stat_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_final_add_scheduler.sv
// Self-checking bench for final_add_scheduler: directed scenarios plus random traffic
// compared against a cycle-indexed transaction model.
module tb_final_add_scheduler;

    localparam int WIDTH = 16;
    localparam int PB    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [PB-1:0]    cfg_pipes = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic [WIDTH-1:0] add_in1;
    logic [WIDTH-1:0] add_in2;
    logic [PB-1:0]    add_pipes;
    logic [WIDTH-1:0] add_out;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             busy;
`ifdef FINAL_ADD_SCHED_STATS_EN
    logic [15:0]      stat_ops;
`endif

    final_add_scheduler #(.WIDTH(WIDTH), .PIPELINE_BITS(PB)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_pipes(cfg_pipes), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .add_in1(add_in1), .add_in2(add_in2), .add_pipes(add_pipes), .add_out(add_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
`ifdef FINAL_ADD_SCHED_STATS_EN
        , .stat_ops(stat_ops)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural shared adder: sum delayed by the latency selected through add_pipes.
    logic [WIDTH-1:0] apipe [1:7];
    always @(posedge clk) begin
        apipe[1] <= add_in1 + add_in2;
        for (int k = 2; k <= 7; k++) apipe[k] <= apipe[k-1];
    end
    always_comb begin
        case (add_pipes)
            3'd0:    add_out = add_in1 + add_in2;
            3'd4:    add_out = apipe[7];
            default: add_out = apipe[add_pipes];
        endcase
    end

    typedef struct {
        int               due;
        bit               id;
        logic [WIDTH-1:0] sum;
    } op_t;

    op_t q[$];
    int  cyc;
    int  m_resume;
    int  m_switch;
    int  m_pipes;
    int  m_new;
    bit  m_last;
    int  m_rsp_count;
    int  n_assert = 0;
    int  n_fail   = 0;

    function automatic int lat_of(input int p);
        return (p == 4) ? 7 : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cyc         = 0;
        m_resume    = 0;
        m_switch    = -1;
        m_pipes     = 0;
        m_new       = 0;
        m_last      = 1'b1;
        m_rsp_count = 0;
    endtask

    task automatic checkOutput();
        bit               run;
        bit               g_valid;
        bit               g_id;
        bit               exp_rv;
        int               last_due;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        if (m_switch == cyc) m_pipes = m_new;
        run     = (cyc >= m_resume);
        g_valid = run && (req0_valid || req1_valid);
        g_id    = (req0_valid && req1_valid) ? !m_last : req1_valid;
        ea      = g_valid ? (g_id ? req1_a : req0_a) : '0;
        eb      = g_valid ? (g_id ? req1_b : req0_b) : '0;
        chk("req0_ready", 32'(req0_ready), 32'(g_valid && !g_id));
        chk("req1_ready", 32'(req1_ready), 32'(g_valid && g_id));
        chk("cfg_ready",  32'(cfg_ready),  32'(run));
        chk("cfg_err",    32'(cfg_err),    32'(run && cfg_valid && (cfg_pipes > 3'd4)));
        chk("add_pipes",  32'(add_pipes),  32'(m_pipes));
        chk("busy",       32'(busy),       32'(!run || (q.size() > 0)));
        chk("add_in1",    32'(add_in1),    32'(ea));
        chk("add_in2",    32'(add_in2),    32'(eb));
        if (g_valid) begin
            q.push_back('{due: cyc + lat_of(m_pipes), id: g_id, sum: WIDTH'(ea + eb)});
            m_last = g_id;
        end
        exp_rv = (q.size() > 0) && (q[0].due == cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id",  32'(rsp_id),  32'(q[0].id));
            chk("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
            void'(q.pop_front());
            m_rsp_count++;
        end
        if (run && cfg_valid && (cfg_pipes <= 3'd4)) begin
            last_due = (q.size() > 0) ? q[$].due : cyc;
            if (last_due < cyc) last_due = cyc;
            m_resume = last_due + 3;
            m_switch = m_resume - 1;
            m_new    = int'(cfg_pipes);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input bit v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input bit cv, input logic [PB-1:0] cp);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        cfg_valid  = cv; cfg_pipes = cp;
        #2;
        checkOutput();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic waitRun();
        for (int k = 0; k < 20 && cyc < m_resume; k++) idle(1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; cfg_valid = 1'b1; cfg_pipes = 3'd6;
        #2;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_cfg_ready",  32'(cfg_ready),  32'd0);
        chk("rst_cfg_err",    32'(cfg_err),    32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_add_pipes",  32'(add_pipes),  32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; cfg_valid = 1'b0; cfg_pipes = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'($urandom_range(0, 65535));
    endfunction

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] pipes=0 same-cycle response");
        applyStimulus(1, 16'd1, 16'd2, 0, 0, 0, 0, 0);
        idle(1);

        $display("[TB] pipes=4 seven-cycle latency");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd4);
        waitRun();
        applyStimulus(0, 0, 0, 1, 16'd4562, 16'd4544, 0, 0);
        idle(8);

        $display("[TB] pipes=2 round-robin contention");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd2);
        waitRun();
        for (int k = 0; k < 4; k++) applyStimulus(1, rnd(), rnd(), 1, rnd(), rnd(), 0, 0);
        idle(3);

        $display("[TB] pipes=3 drain then switch to pipes=1");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd3);
        waitRun();
        applyStimulus(1, rnd(), rnd(), 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, rnd(), rnd(), 0, 0);
        applyStimulus(1, rnd(), rnd(), 0, 0, 0, 1, 3'd1);
        for (int k = 0; k < 20 && cyc < m_resume; k++) applyStimulus(1, rnd(), rnd(), 1, rnd(), rnd(), 0, 0);
        applyStimulus(1, rnd(), rnd(), 0, 0, 0, 0, 0);
        idle(2);

        $display("[TB] illegal cfg_pipes value");
        applyStimulus(1, rnd(), rnd(), 1, rnd(), rnd(), 1, 3'd6);
        applyStimulus(1, rnd(), rnd(), 1, rnd(), rnd(), 1, 3'd7);
        applyStimulus(0, 0, 0, 1, rnd(), rnd(), 0, 0);
        idle(2);

        $display("[TB] reset with operations in flight");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd4);
        waitRun();
        applyStimulus(1, rnd(), rnd(), 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, rnd(), rnd(), 0, 0);
        doReset();
        idle(8);
        applyStimulus(1, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0);
        idle(1);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 99) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), rnd(), rnd(),
                              1'($urandom_range(0, 1)), rnd(), rnd(),
                              (r < 6), 3'($urandom_range(0, 7)));
            end
        end
        idle(10);

`ifdef FINAL_ADD_SCHED_STATS_EN
        chk("stat_ops", 32'(stat_ops), 32'(m_rsp_count));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/final_add_scheduler.md
FINAL_ADD_SCHEDULER -- requirements
Module: final_add_scheduler

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width.
REQ-002 Parameter PIPELINE_BITS, default 3: width of the pipes setting.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cfg_valid  in  1 / cfg_pipes  in  PIPELINE_BITS / cfg_ready  out  1: request to change the adder pipe setting.
REQ-006 cfg_err  out  1: one-cycle pulse when an illegal cfg_pipes value is offered.
REQ-007 reqN_valid  in  1 / reqN_ready  out  1 / reqN_a, reqN_b  in  WIDTH each, for N=0,1: requester ports.
REQ-008 add_in1, add_in2  out  WIDTH / add_pipes  out  PIPELINE_BITS / add_out  in  WIDTH: connection to the shared pipelined final adder.
REQ-009 rsp_valid  out  1 / rsp_id  out  1 / rsp_sum  out  WIDTH: result stream, no backpressure.
REQ-010 busy  out  1: high when any operation is in flight or the state is not RUN.

Function
REQ-011 Adder latency L SHALL be derived from add_pipes: 0->0, 1->1, 2->2, 3->3, 4->7 cycles; values 5-7 are illegal.
REQ-012 A handshake (reqN_valid & reqN_ready) SHALL drive add_in1/add_in2 combinationally with reqN_a/reqN_b in that cycle; with no issue, add_in1/add_in2 SHALL be 0.
REQ-013 At most one request SHALL be granted per cycle; reqN_ready SHALL be high only in RUN and only for the granted requester.
REQ-014 Arbitration SHALL be round-robin: if both valid, grant the requester not granted most recently; a single valid requester is granted immediately.
REQ-015 An operation issued in cycle t SHALL produce rsp_valid=1, rsp_id=N, rsp_sum=add_out in cycle t+L; L=0 gives a same-cycle combinational response.
REQ-016 In-flight tracking SHALL be a 7-deep valid/id shift register tapped at L; results SHALL return in issue order with no loss or duplication.
REQ-017 FSM states: RUN, DRAIN, SWITCH.
REQ-018 RUN: cfg_ready=1; a cfg_valid with legal cfg_pipes SHALL latch the new value and move to DRAIN next cycle.
REQ-019 RUN with illegal cfg_pipes (5-7): cfg_err pulses for that cycle, no state or add_pipes change.
REQ-020 A request and a config offered in the same RUN cycle SHALL both be accepted; the request completes with the old L.
REQ-021 DRAIN: no grants, cfg_ready=0; leave for SWITCH in the cycle after the tracker becomes empty (immediately if already empty).
REQ-022 SWITCH: add_pipes takes the latched value at entry, no grants for one cycle, then RUN.
REQ-023 Config to the current value SHALL still traverse DRAIN and SWITCH.
REQ-024 rsp_sum SHALL be the WIDTH-bit modulo sum; carry-out is discarded.

Reset
REQ-025 On rst: state RUN, add_pipes=0, tracker cleared, round-robin pointer set so req0 wins the first contention.
REQ-026 On rst: rsp_valid=0, rsp_id=0, rsp_sum=add_out pass-through, cfg_err=0, busy=0, all readies low while rst asserted.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; no rsp_valid is produced for them after deassertion.

Configuration
REQ-028 Macro FINAL_ADD_SCHED_STATS_EN, when defined, SHALL add output stat_ops[15:0]: saturating count of rsp_valid cycles, cleared by rst.
REQ-029 Without FINAL_ADD_SCHED_STATS_EN the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 pipes=0, req0 a=1 b=2 -> same-cycle rsp_valid, rsp_id=0, rsp_sum=3.
REQ-031 cfg_pipes=4, then req1 a=4562 b=4544 at cycle t -> rsp_sum=9106, rsp_id=1 exactly at t+7; no rsp at t+1..t+6.
REQ-032 pipes=2, req0 and req1 both valid 4 cycles -> grants alternate 0,1,0,1; responses in the same order at +2.
REQ-033 pipes=3, 3 ops in flight, cfg_pipes=1 -> readies low until the tracker drains, one SWITCH cycle, then add_pipes=1, next op returns at +1.
REQ-034 cfg_pipes=6 -> cfg_err one-cycle pulse, add_pipes unchanged, grants continue.
REQ-035 pipes=4, 2 ops in flight, rst pulsed -> no rsp_valid afterwards, add_pipes=0; a=0xFFFF b=0x0001 afterwards -> rsp_sum=0x0000.
